// File: rtl/apb_ucpd_rx_fifo.sv
// rtl/apb_ucpd_rx_fifo.sv - UCPD receive byte FIFO with payload count and sticky RX flags
module apb_ucpd_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          ic_clk,
  input  logic          ic_rst_n,
  input  logic          ucpden,
  input  logic [7:0]    rx_byte,
  input  logic          rx_byte_vld,
  input  logic          rx_msg_end,
  input  logic          rx_crc_ok,
  input  logic          rx_msg_abort,
  input  logic          rxdr_rd,
  input  logic          clr_rxovr,
  input  logic          clr_rxmsgend,
  output logic [7:0]    rxdr,
  output logic          rxne,
  output logic [AW:0]   rx_level,
  output logic [9:0]    rx_paysize,
  output logic          rxovr,
  output logic          rxmsgend,
  output logic          rxerr
);

  localparam logic [AW:0] LP_FULL    = (AW+1)'(DEPTH);
  localparam logic [9:0]  LP_PAY_MAX = 10'd1023;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [9:0]    r_paysize;
  logic          r_msg_done;
  logic          r_ovr_in_msg;
  logic          r_rxovr;
  logic          r_rxmsgend;
  logic          r_rxerr;

  logic w_live;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_new_msg;
  logic w_msg_end;
  logic w_oim_next;
  logic w_err_set;

  // Strobes only act when enabled and not being aborted; abort/disable win over everything.
  assign w_live     = ucpden & ~rx_msg_abort;
  assign w_full     = (r_count == LP_FULL);
  assign w_empty    = (r_count == '0);
  assign w_pop      = w_live & rxdr_rd & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push     = w_live & rx_byte_vld & (~w_full | rxdr_rd);
  assign w_drop     = w_live & rx_byte_vld & w_full & ~rxdr_rd;
  assign w_new_msg  = w_live & rx_byte_vld & r_msg_done;
  assign w_msg_end  = w_live & rx_msg_end;
  // Overrun history of the message being received, including this cycle's drop.
  assign w_oim_next = (r_ovr_in_msg & ~w_new_msg) | w_drop;
  assign w_err_set  = w_msg_end & (~rx_crc_ok | w_oim_next);

  // Byte storage; contents are don't-care until written, output is masked by count.
  always_ff @(posedge ic_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= rx_byte;
    end
  end

  // Pointers, occupancy and per-message bookkeeping.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_paysize    <= '0;
      r_msg_done   <= 1'b0;
      r_ovr_in_msg <= 1'b0;
    end else if (!ucpden || rx_msg_abort) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_paysize    <= '0;
      r_msg_done   <= 1'b0;
      r_ovr_in_msg <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
      if (w_new_msg) begin
        r_paysize <= w_push ? 10'd1 : 10'd0;
      end else if (w_push && (r_paysize != LP_PAY_MAX)) begin
        r_paysize <= r_paysize + 10'd1;
      end
      if (w_msg_end) begin
        r_msg_done <= 1'b1;
      end else if (w_new_msg) begin
        r_msg_done <= 1'b0;
      end
      r_ovr_in_msg <= w_oim_next;
    end
  end

  // Sticky status flags; a set in the same cycle as its clear wins.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      r_rxovr    <= 1'b0;
      r_rxmsgend <= 1'b0;
      r_rxerr    <= 1'b0;
    end else if (!ucpden) begin
      r_rxovr    <= 1'b0;
      r_rxmsgend <= 1'b0;
      r_rxerr    <= 1'b0;
    end else begin
      r_rxovr    <= w_drop    | (r_rxovr    & ~clr_rxovr);
      r_rxmsgend <= w_msg_end | (r_rxmsgend & ~clr_rxmsgend);
      r_rxerr    <= w_err_set | (r_rxerr    & ~clr_rxmsgend);
    end
  end

  assign rxdr       = w_empty ? 8'h00 : r_mem[r_rptr];
  assign rxne       = ~w_empty;
  assign rx_level   = r_count;
  assign rx_paysize = r_paysize;
  assign rxovr      = r_rxovr;
  assign rxmsgend   = r_rxmsgend;
  assign rxerr      = r_rxerr;

endmodule

// File: tb/tb_apb_ucpd_rx_fifo.sv
// tb/tb_apb_ucpd_rx_fifo.sv - self-checking bench for apb_ucpd_rx_fifo
module tb_apb_ucpd_rx_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          ic_clk = 1'b0;
  logic          ic_rst_n = 1'b0;
  logic          ucpden = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_byte_vld = 1'b0;
  logic          rx_msg_end = 1'b0;
  logic          rx_crc_ok = 1'b0;
  logic          rx_msg_abort = 1'b0;
  logic          rxdr_rd = 1'b0;
  logic          clr_rxovr = 1'b0;
  logic          clr_rxmsgend = 1'b0;
  logic [7:0]    rxdr;
  logic          rxne;
  logic [AW:0]   rx_level;
  logic [9:0]    rx_paysize;
  logic          rxovr;
  logic          rxmsgend;
  logic          rxerr;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_q[$];
  int         m_pay;
  bit         m_done, m_oim, m_ovr, m_end, m_err;

  apb_ucpd_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpden(ucpden),
    .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld), .rx_msg_end(rx_msg_end),
    .rx_crc_ok(rx_crc_ok), .rx_msg_abort(rx_msg_abort), .rxdr_rd(rxdr_rd),
    .clr_rxovr(clr_rxovr), .clr_rxmsgend(clr_rxmsgend),
    .rxdr(rxdr), .rxne(rxne), .rx_level(rx_level), .rx_paysize(rx_paysize),
    .rxovr(rxovr), .rxmsgend(rxmsgend), .rxerr(rxerr)
  );

  always #5 ic_clk = ~ic_clk;

  task automatic model_clear_all();
    m_q.delete();
    m_pay = 0; m_done = 0; m_oim = 0; m_ovr = 0; m_end = 0; m_err = 0;
  endtask

  // Behavioural model of one clock edge, using the inputs currently driven.
  task automatic model_step();
    bit pop, acc, drop, new_msg;
    if (!ic_rst_n || !ucpden) begin
      model_clear_all();
      return;
    end
    if (rx_msg_abort) begin
      m_q.delete();
      m_pay = 0; m_done = 0; m_oim = 0;
      if (clr_rxovr) m_ovr = 0;
      if (clr_rxmsgend) begin m_end = 0; m_err = 0; end
      return;
    end
    pop     = rxdr_rd && (m_q.size() > 0);
    acc     = rx_byte_vld && ((m_q.size() < DEPTH) || rxdr_rd);
    drop    = rx_byte_vld && !acc;
    new_msg = rx_byte_vld && m_done;
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(rx_byte);
    if (new_msg) begin
      m_pay = acc ? 1 : 0;
      m_oim = 0;
    end else if (acc && m_pay < 1023) begin
      m_pay = m_pay + 1;
    end
    if (drop) m_oim = 1;
    if (rx_msg_end) m_done = 1;
    else if (new_msg) m_done = 0;
    m_ovr = drop || (m_ovr && !clr_rxovr);
    m_err = (rx_msg_end && (!rx_crc_ok || m_oim)) || (m_err && !clr_rxmsgend);
    m_end = rx_msg_end || (m_end && !clr_rxmsgend);
  endtask

  // One clock with the currently driven inputs; strobes drop afterwards.
  task automatic step();
    @(posedge ic_clk);
    model_step();
    #1;
    rx_byte_vld = 0; rx_msg_end = 0; rx_crc_ok = 0; rx_msg_abort = 0;
    rxdr_rd = 0; clr_rxovr = 0; clr_rxmsgend = 0;
  endtask

  task automatic push(input logic [7:0] b);
    rx_byte = b; rx_byte_vld = 1; step();
  endtask

  task automatic flush();
    ucpden = 0; step(); ucpden = 1;
  endtask

  task automatic test_reset();
    ic_rst_n = 0;
    #12;
    total++; if (rxdr !== 8'h00) begin bad++; $display("FAIL reset_rxdr got=%h exp=00", rxdr); end
    total++; if (rxne !== 1'b0) begin bad++; $display("FAIL reset_rxne got=%b exp=0", rxne); end
    total++; if (rx_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", rx_level); end
    total++; if (rx_paysize !== 10'd0) begin bad++; $display("FAIL reset_paysize got=%0d exp=0", rx_paysize); end
    total++; if ({rxovr, rxmsgend, rxerr} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {rxovr, rxmsgend, rxerr}); end
    ic_rst_n = 1; ucpden = 1;
    model_clear_all();
    @(posedge ic_clk); #1;
  endtask

  task automatic test_fifo_order();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
    flush();
    for (int i = 0; i < 3; i++) push(exp_b[i]);
    total++; if (rx_level !== 3'd3) begin bad++; $display("FAIL order_level got=%0d exp=3", rx_level); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rxdr !== exp_b[i]) begin bad++; $display("FAIL order_rxdr%0d got=%h exp=%h", i, rxdr, exp_b[i]); end
      rxdr_rd = 1; step();
      total++; if (rx_level !== 3'(2 - i)) begin bad++; $display("FAIL order_level%0d got=%0d exp=%0d", i, rx_level, 2 - i); end
    end
    total++; if (rxne !== 1'b0 || rxdr !== 8'h00) begin bad++; $display("FAIL order_empty got rxne=%b rxdr=%h exp 0/00", rxne, rxdr); end
  endtask

  task automatic test_overrun();
    flush();
    for (int i = 1; i <= 5; i++) push(8'(i));
    total++; if (rxovr !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", rxovr); end
    total++; if (rx_level !== 3'd4) begin bad++; $display("FAIL ovr_level got=%0d exp=4", rx_level); end
    total++; if (rx_paysize !== 10'd4) begin bad++; $display("FAIL ovr_paysize got=%0d exp=4", rx_paysize); end
    total++; if (rxdr !== 8'h01) begin bad++; $display("FAIL ovr_head got=%h exp=01", rxdr); end
    rx_msg_end = 1; rx_crc_ok = 1; step();
    total++; if (rxerr !== 1'b1 || rxmsgend !== 1'b1) begin bad++; $display("FAIL ovr_msgend got err=%b end=%b exp 1/1", rxerr, rxmsgend); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h12; exp_b[2] = 8'h13; exp_b[3] = 8'h77;
    flush();
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    rxdr_rd = 1; rx_byte = 8'h77; rx_byte_vld = 1; step();
    total++; if (rxovr !== 1'b0) begin bad++; $display("FAIL fullpp_ovr got=%b exp=0", rxovr); end
    total++; if (rx_level !== 3'd4) begin bad++; $display("FAIL fullpp_level got=%0d exp=4", rx_level); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rxdr !== exp_b[i]) begin bad++; $display("FAIL fullpp_rxdr%0d got=%h exp=%h", i, rxdr, exp_b[i]); end
      rxdr_rd = 1; step();
    end
  endtask

  task automatic test_crc_error();
    flush();
    push(8'h21); push(8'h22);
    rx_msg_end = 1; rx_crc_ok = 0; step();
    total++; if (rxmsgend !== 1'b1 || rxerr !== 1'b1) begin bad++; $display("FAIL crc_flags got end=%b err=%b exp 1/1", rxmsgend, rxerr); end
    total++; if (rx_paysize !== 10'd2) begin bad++; $display("FAIL crc_paysize got=%0d exp=2", rx_paysize); end
    push(8'h31);
    total++; if (rx_paysize !== 10'd1) begin bad++; $display("FAIL crc_newmsg_paysize got=%0d exp=1", rx_paysize); end
    clr_rxmsgend = 1; rx_msg_end = 1; rx_crc_ok = 0; step();
    total++; if (rxmsgend !== 1'b1 || rxerr !== 1'b1) begin bad++; $display("FAIL crc_setwins got end=%b err=%b exp 1/1", rxmsgend, rxerr); end
    clr_rxmsgend = 1; step();
    total++; if (rxmsgend !== 1'b0 || rxerr !== 1'b0) begin bad++; $display("FAIL crc_clear got end=%b err=%b exp 0/0", rxmsgend, rxerr); end
  endtask

  task automatic test_abort_enable();
    flush();
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    rx_msg_end = 1; rx_crc_ok = 1; step();
    rx_msg_abort = 1; rx_byte = 8'h55; rx_byte_vld = 1; step();
    total++; if (rx_level !== 3'd0 || rxne !== 1'b0) begin bad++; $display("FAIL abort_level got=%0d ne=%b exp 0/0", rx_level, rxne); end
    total++; if (rx_paysize !== 10'd0) begin bad++; $display("FAIL abort_paysize got=%0d exp=0", rx_paysize); end
    total++; if ({rxovr, rxmsgend, rxerr} !== 3'b111) begin bad++; $display("FAIL abort_flags got=%b exp=111", {rxovr, rxmsgend, rxerr}); end
    push(8'h66); push(8'h67);
    total++; if (rx_paysize !== 10'd2) begin bad++; $display("FAIL abort_next_paysize got=%0d exp=2", rx_paysize); end
    ucpden = 0; rx_byte = 8'h68; rx_byte_vld = 1; rx_msg_end = 1; step();
    total++; if ({rxovr, rxmsgend, rxerr} !== 3'b000) begin bad++; $display("FAIL dis_flags got=%b exp=000", {rxovr, rxmsgend, rxerr}); end
    total++; if (rx_level !== 3'd0 || rx_paysize !== 10'd0) begin bad++; $display("FAIL dis_state got lvl=%0d pay=%0d exp 0/0", rx_level, rx_paysize); end
    ucpden = 1;
  endtask

  task automatic test_async_reset();
    flush();
    push(8'h81); push(8'h82);
    rx_msg_end = 1; rx_crc_ok = 0; step();
    total++; if (rx_level !== 3'd2) begin bad++; $display("FAIL arst_pre_level got=%0d exp=2", rx_level); end
    #2 ic_rst_n = 0;
    #1;
    total++; if ({rxdr, rxne, rx_level, rx_paysize, rxovr, rxmsgend, rxerr} !== '0) begin
      bad++; $display("FAIL arst_outputs got rxdr=%h ne=%b lvl=%0d pay=%0d flags=%b exp all 0",
                      rxdr, rxne, rx_level, rx_paysize, {rxovr, rxmsgend, rxerr});
    end
    #1 ic_rst_n = 1;
    model_clear_all();
    @(posedge ic_clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] exp_rxdr;
    flush();
    for (int c = 0; c < 600; c++) begin
      ucpden       = ($urandom_range(0, 79) != 0);
      rx_byte      = 8'($urandom);
      rx_byte_vld  = ($urandom_range(0, 2) != 0);
      rxdr_rd      = ($urandom_range(0, 2) == 0);
      rx_msg_end   = ($urandom_range(0, 9) == 0);
      rx_crc_ok    = ($urandom_range(0, 2) != 0);
      rx_msg_abort = ($urandom_range(0, 59) == 0);
      clr_rxovr    = ($urandom_range(0, 7) == 0);
      clr_rxmsgend = ($urandom_range(0, 7) == 0);
      step();
      ucpden = 1;
      exp_rxdr = (m_q.size() > 0) ? m_q[0] : 8'h00;
      total++; if (rxdr !== exp_rxdr) begin bad++; $display("FAIL rnd_rxdr c=%0d got=%h exp=%h", c, rxdr, exp_rxdr); end
      total++; if (rx_level !== 3'(m_q.size()) || rxne !== (m_q.size() > 0)) begin bad++; $display("FAIL rnd_level c=%0d got=%0d/%b exp=%0d", c, rx_level, rxne, m_q.size()); end
      total++; if (rx_paysize !== 10'(m_pay)) begin bad++; $display("FAIL rnd_paysize c=%0d got=%0d exp=%0d", c, rx_paysize, m_pay); end
      total++; if ({rxovr, rxmsgend, rxerr} !== {m_ovr, m_end, m_err}) begin bad++; $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, {rxovr, rxmsgend, rxerr}, {m_ovr, m_end, m_err}); end
    end
  endtask

  initial begin
    model_clear_all();
    test_reset();
    test_fifo_order();
    test_overrun();
    test_full_pushpop();
    test_crc_error();
    test_abort_enable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
